// File: rtl/l2_arb_pkg.sv
// Shared encodings for the L2 port arbiter:
// FSM state and latched L2 operation.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_L2 = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts one past
// the last granted requester and wraps.
module rr_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_valid
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!o_valid && i_req[(int'(i_last) + k) % NUM_REQ]) begin
                o_valid = 1'b1;
                o_idx   = IW'((int'(i_last) + k) % NUM_REQ);
                o_grant[(int'(i_last) + k) % NUM_REQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port among NUM_REQ L1 requesters, one transaction at a time.
// Define L2_ARB_TIMEOUT_EN to abort L2 waits after TIMEOUT_CYCLES cycles.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          req_hit,
    output logic                          req_err,
    output logic [ADDR_WIDTH-1:0]         l2_cache_addr,
    output logic [DATA_WIDTH-1:0]         l2_cache_data_out,
    output logic                          l2_cache_read,
    output logic                          l2_cache_write,
    input  logic [DATA_WIDTH-1:0]         l2_cache_data_in,
    input  logic                          l2_cache_ready,
    input  logic                          l2_cache_hit
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES - 1);
`ifdef L2_ARB_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    state_e                  r_state;
    state_e                  w_next;
    op_e                     r_op;
    logic                    r_cmd;
    logic [IW-1:0]           r_last_grant;
    logic [IW-1:0]           r_grant_idx;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_hit;
    logic                    r_err;
    logic [TW-1:0]           r_timer;

    logic [NUM_REQ-1:0]      w_req;
    logic [NUM_REQ-1:0]      w_grant;
    logic [IW-1:0]           w_idx;
    logic                    w_any;
    logic                    w_is_wr;
    logic                    w_timeout;
    logic                    w_resp;

    assign w_req   = req_read | req_write;
    assign w_is_wr = |(w_grant & req_write);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .i_req   (w_req),
        .i_last  (r_last_grant),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign w_timeout = TO_EN && (r_state == ST_WAIT_L2) &&
                       !l2_cache_ready && (r_timer == TO_LIM);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_any) w_next = ST_WAIT_L2;
            ST_WAIT_L2: if (l2_cache_ready || w_timeout) w_next = ST_RESPOND;
            ST_RESPOND: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op         <= OP_READ;
            r_cmd        <= 1'b0;
            r_last_grant <= IW'(NUM_REQ - 1);
            r_grant_idx  <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_hit        <= 1'b0;
            r_err        <= 1'b0;
            r_timer      <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_any) begin
                r_grant_idx  <= w_idx;
                r_last_grant <= w_idx;
                r_addr       <= req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata      <= req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
                r_op         <= w_is_wr ? OP_WRITE : OP_READ;
                r_cmd        <= 1'b1;
                r_rdata      <= '0;
                r_hit        <= 1'b0;
                r_err        <= 1'b0;
                r_timer      <= '0;
            end
        end else if (r_state == ST_WAIT_L2) begin
            if (l2_cache_ready) begin
                r_rdata <= l2_cache_data_in;
                r_hit   <= l2_cache_hit;
                r_err   <= 1'b0;
                r_cmd   <= 1'b0;
            end else if (w_timeout) begin
                // Abort returns a clean zero payload flagged as an error
                r_rdata <= '0;
                r_hit   <= 1'b0;
                r_err   <= 1'b1;
                r_cmd   <= 1'b0;
            end else if (TO_EN) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign w_resp = (r_state == ST_RESPOND);

    assign req_ready = w_resp ?
        ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_idx) : '0;
    assign req_rdata = w_resp ? r_rdata : '0;
    assign req_hit   = w_resp & r_hit;
    assign req_err   = TO_EN ? (w_resp & r_err) : 1'b0;

    assign l2_cache_addr     = r_addr;
    assign l2_cache_data_out = r_wdata;
    assign l2_cache_read     = r_cmd && (r_op == OP_READ);
    assign l2_cache_write    = r_cmd && (r_op == OP_WRITE);

endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, giving the address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the data word width.
REQ-003 SHALL have parameter NUM_REQ, default 2, legal range 2..4, giving the number of L1 requesters.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the L2 wait limit (used only when L2_ARB_TIMEOUT_EN is defined).
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_addr  input  NUM_REQ*ADDR_WIDTH  per-requester address; slice i belongs to requester i.
REQ-008 req_wdata  input  NUM_REQ*DATA_WIDTH  per-requester write data.
REQ-009 req_read  input  NUM_REQ  per-requester read request, level, held until its req_ready.
REQ-010 req_write  input  NUM_REQ  per-requester write request, level, held until its req_ready.
REQ-011 req_rdata  output  DATA_WIDTH  shared read-data return, valid only with a req_ready bit.
REQ-012 req_ready  output  NUM_REQ  one-hot, single-cycle completion pulse.
REQ-013 req_hit  output  1  L2 hit flag for the completing transaction, valid with req_ready.
REQ-014 req_err  output  1  timeout-abort flag, valid with req_ready.
REQ-015 l2_cache_addr / l2_cache_data_out  output  ADDR_WIDTH / DATA_WIDTH  latched address and write data to L2.
REQ-016 l2_cache_read / l2_cache_write  output  1 each  L2 command, level, held until l2_cache_ready.
REQ-017 l2_cache_data_in  input  DATA_WIDTH  L2 read data; l2_cache_ready  input  1  L2 done; l2_cache_hit  input  1  L2 hit.

Function
REQ-018 SHALL implement FSM IDLE -> WAIT_L2 -> RESPOND -> IDLE, serving exactly one transaction at a time.
REQ-019 In IDLE, if any requester has read or write asserted, SHALL grant one requester by round-robin, search starting at (last_grant+1) mod NUM_REQ, then go to WAIT_L2.
REQ-020 On grant SHALL latch address, write data and operation; a requester asserting both read and write SHALL be treated as a write.
REQ-021 In WAIT_L2, SHALL hold l2_cache_read or l2_cache_write high from the cycle after grant until the cycle l2_cache_ready is sampled high.
REQ-022 When l2_cache_ready is sampled high, SHALL capture l2_cache_data_in and l2_cache_hit, drop the L2 command on the next edge and enter RESPOND.
REQ-023 In RESPOND, SHALL pulse req_ready[grant] for exactly one cycle with req_rdata/req_hit/req_err valid; the requester drops its request in that cycle.
REQ-024 Latency: request seen in IDLE at cycle N -> L2 command asserted at N+1; l2_cache_ready at cycle M -> req_ready at M+1; minimum 3 cycles.
REQ-025 Requests arriving while not IDLE SHALL be held pending, not lost; a requester never waits more than NUM_REQ-1 other transactions.
REQ-026 last_grant SHALL update only on grant; address/data changes after grant SHALL not affect the active transaction.
REQ-027 l2_cache_ready asserted outside WAIT_L2 SHALL be ignored.

Reset
REQ-028 rst at any edge, including mid-transaction, SHALL force IDLE, all outputs 0, last_grant = NUM_REQ-1 (requester 0 wins first), and the timeout counter to 0.

Configuration
REQ-029 With L2_ARB_TIMEOUT_EN defined, a WAIT_L2 counter SHALL abort after TIMEOUT_CYCLES cycles without l2_cache_ready: drop the L2 command, then RESPOND with req_err=1, req_hit=0, req_rdata=0.
REQ-030 Without L2_ARB_TIMEOUT_EN, WAIT_L2 SHALL wait indefinitely and req_err SHALL be constant 0.

Structure
REQ-031 Package l2_arb_pkg SHALL hold the FSM state encoding (2 bits) and the operation encoding (READ/WRITE).
REQ-032 Grant selection SHALL be a sub-module rr_arbiter (inputs request vector and last_grant, output one-hot grant plus index).

Verification
REQ-033 Single read: req_read=01, addr 0x100; L2 ready after 2 cycles with data 0xDEADBEEF, hit=1 -> req_ready=01 once, req_rdata=0xDEADBEEF, req_hit=1.
REQ-034 Contention: req_read=11 held after reset -> requester 0 served first, then 1; grants alternate 0,1,0,1 over 4 transactions.
REQ-035 Read+write same requester: req_read=req_write=1, wdata 0x5A5A5A5A -> l2_cache_write=1, l2_cache_read=0, l2_cache_data_out=0x5A5A5A5A.
REQ-036 Reset mid-WAIT_L2: rst high one cycle -> next cycle l2_cache_read=0, req_ready=0; a later ready pulse is ignored.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=8): l2_cache_ready never asserted -> after 8 cycles req_ready pulses with req_err=1, req_rdata=0.
